// File: rtl/riscv_cpu_pkg.sv
// Shared constants and types for the RV32I instruction fetch front end.
// The HALT state exists only when RISCV_FETCH_BUS_ERR_EN is defined.
package riscv_cpu_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        FETCH_START = 2'd0,
        FETCH_RUN   = 2'd1
`ifdef RISCV_FETCH_BUS_ERR_EN
        , FETCH_HALT = 2'd2
`endif
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with flush, occupancy count and
// simultaneous push/pop; the head entry is read straight from storage.
module riscv_fetch_fifo
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/riscv_cpu_fetch_unit.sv
// RV32I fetch front end: pipelined AHB-Lite word fetches into a prefetch FIFO.
// Define RISCV_FETCH_BUS_ERR_EN to honour hresp and halt fetching on bus errors.
module riscv_cpu_fetch_unit
    import riscv_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
)(
    input  logic        cpu_clk,
    input  logic        cpu_resetn,
    output logic [31:0] imem_m_ahb_haddr,
    output logic [2:0]  imem_m_ahb_hsize,
    output logic [1:0]  imem_m_ahb_htrans,
    output logic [31:0] imem_m_ahb_hwdata,
    output logic [3:0]  imem_m_ahb_hwstrb,
    output logic        imem_m_ahb_hwrite,
    input  logic [31:0] imem_m_ahb_hrdata,
    input  logic        imem_m_ahb_hreadyin,
    input  logic        imem_m_ahb_hresp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic             w_run_nxt;

    logic [31:0]      r_pc;
    logic [31:0]      r_haddr;
    logic [1:0]       r_htrans;
    logic             r_astale;
    logic             r_dvalid;
    logic [31:0]      r_dpc;
    logic             r_dstale;

    logic             w_acc;
    logic             w_dcomp;
    logic             w_hold;
    logic             w_err1;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_pc_nxt;
    logic             w_dvalid_nxt;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_issue_nxt;
    fetch_entry_t     w_push_data;
    fetch_entry_t     w_head;
    logic             w_head_valid;
    logic             w_unused;

    assign w_acc   = (r_htrans == HTRANS_NONSEQ) && imem_m_ahb_hreadyin;
    assign w_dcomp = r_dvalid && imem_m_ahb_hreadyin;
    assign w_hold  = (r_htrans == HTRANS_NONSEQ) && !imem_m_ahb_hreadyin && !w_err1;
    assign w_push  = w_dcomp && !r_dstale && !redirect_valid;
    assign w_pop   = w_head_valid && if_ready;

`ifdef RISCV_FETCH_BUS_ERR_EN
    // First cycle of the two-cycle error response on a live data phase.
    assign w_err1   = r_dvalid && imem_m_ahb_hresp && !imem_m_ahb_hreadyin;
    assign w_unused = ^redirect_pc[1:0];
    always_comb begin
        w_push_data       = '0;
        w_push_data.pc    = r_dpc;
        w_push_data.instr = imem_m_ahb_hresp ? 32'h0 : imem_m_ahb_hrdata;
        w_push_data.err   = imem_m_ahb_hresp;
    end
`else
    assign w_err1   = 1'b0;
    assign w_unused = ^{imem_m_ahb_hresp, redirect_pc[1:0]};
    always_comb begin
        w_push_data       = '0;
        w_push_data.pc    = r_dpc;
        w_push_data.instr = imem_m_ahb_hrdata;
        w_push_data.err   = 1'b0;
    end
`endif

    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            r_state <= FETCH_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH_START: w_state_nxt = FETCH_RUN;
            FETCH_RUN: begin
                w_state_nxt = FETCH_RUN;
`ifdef RISCV_FETCH_BUS_ERR_EN
                if (w_err1 && !r_dstale && !redirect_valid) begin
                    w_state_nxt = FETCH_HALT;
                end
`endif
            end
`ifdef RISCV_FETCH_BUS_ERR_EN
            FETCH_HALT: begin
                if (redirect_valid) begin
                    w_state_nxt = FETCH_RUN;
                end
            end
`endif
            default: w_state_nxt = FETCH_START;
        endcase
    end

    always_comb begin
        w_run_nxt = 1'b0;
        if (w_state_nxt == FETCH_RUN) begin
            w_run_nxt = 1'b1;
        end
    end

    // Next-cycle bookkeeping; the issue decision uses post-edge occupancy.
    always_comb begin
        w_pc_nxt = r_pc;
        if (redirect_valid) begin
            w_pc_nxt = {redirect_pc[31:2], 2'b00};
        end else if (w_acc && !r_astale) begin
            w_pc_nxt = r_pc + 32'd4;
        end

        w_dvalid_nxt = r_dvalid;
        if (w_acc) begin
            w_dvalid_nxt = 1'b1;
        end else if (w_dcomp) begin
            w_dvalid_nxt = 1'b0;
        end

        w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (redirect_valid) begin
            w_count_nxt = '0;
        end

        w_issue_nxt = w_run_nxt &&
                      ((32'(w_count_nxt) + 32'(w_dvalid_nxt)) < FIFO_DEPTH);
    end

    // A stalled address stays on the bus; a redirect only marks it stale.
    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            r_pc     <= RESET_VECTOR;
            r_haddr  <= RESET_VECTOR;
            r_htrans <= HTRANS_IDLE;
            r_astale <= 1'b0;
            r_dvalid <= 1'b0;
            r_dpc    <= '0;
            r_dstale <= 1'b0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_dvalid <= w_dvalid_nxt;
            if (w_hold) begin
                r_astale <= r_astale || redirect_valid;
            end else begin
                r_haddr  <= w_pc_nxt;
                r_htrans <= w_issue_nxt ? HTRANS_NONSEQ : HTRANS_IDLE;
                r_astale <= 1'b0;
            end
            if (w_acc) begin
                r_dpc    <= r_haddr;
                r_dstale <= r_astale || redirect_valid;
            end else if (redirect_valid) begin
                r_dstale <= 1'b1;
            end
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (cpu_clk),
        .rst_n   (cpu_resetn),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_head_valid),
        .o_count (w_count)
    );

    assign imem_m_ahb_haddr  = r_haddr;
    assign imem_m_ahb_htrans = w_err1 ? HTRANS_IDLE : r_htrans;
    assign imem_m_ahb_hsize  = HSIZE_WORD;
    assign imem_m_ahb_hwdata = 32'h0;
    assign imem_m_ahb_hwstrb = 4'h0;
    assign imem_m_ahb_hwrite = 1'b0;

    assign if_valid = w_head_valid;
    assign if_pc    = w_head.pc;
    assign if_instr = w_head.instr;
    assign if_err   = w_head.err;

endmodule

// File: tb/tb_riscv_cpu_fetch_unit.sv
// Directed bench for riscv_cpu_fetch_unit against a simple zero/wait-state AHB slave.
module tb_riscv_cpu_fetch_unit;
    import riscv_cpu_pkg::*;

    localparam logic [31:0] MAGIC = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        hwrite;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_err;

    int total = 0;
    int bad   = 0;
    int n_acc;

    riscv_cpu_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .FIFO_DEPTH   (4)
    ) dut (
        .cpu_clk             (clk),
        .cpu_resetn          (rst_n),
        .imem_m_ahb_haddr    (haddr),
        .imem_m_ahb_hsize    (hsize),
        .imem_m_ahb_htrans   (htrans),
        .imem_m_ahb_hwdata   (hwdata),
        .imem_m_ahb_hwstrb   (hwstrb),
        .imem_m_ahb_hwrite   (hwrite),
        .imem_m_ahb_hrdata   (hrdata),
        .imem_m_ahb_hreadyin (hready),
        .imem_m_ahb_hresp    (hresp),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .if_valid            (if_valid),
        .if_ready            (if_ready),
        .if_pc               (if_pc),
        .if_instr            (if_instr),
        .if_err              (if_err)
    );

    always #5 clk = ~clk;

    // Slave: latch the accepted address, return a scrambled copy in the data phase.
    logic [31:0] s_daddr = 32'h0;
    always @(posedge clk) begin
        if (hready && htrans == HTRANS_NONSEQ) s_daddr <= haddr;
    end
    assign hrdata = s_daddr ^ MAGIC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ MAGIC;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its START cycle, with inputs at their idle values.
    task automatic do_reset();
        rst_n          = 1'b0;
        hready         = 1'b1;
        hresp          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        if_ready = 1'b1;
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_htrans",   32'(htrans), 32'(HTRANS_IDLE));
        check("rst_haddr",    haddr, 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_pc",    if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_err",   32'(if_err), 32'h0);
        check("const_hsize",  32'(hsize), 32'(HSIZE_WORD));
        check("const_hwrite", 32'(hwrite), 32'h0);
        check("const_hwdata", hwdata, 32'h0);
        check("const_hwstrb", 32'(hwstrb), 32'h0);

        // Zero-wait streaming
        do_reset();
        check("start_idle", 32'(htrans), 32'(HTRANS_IDLE));
        tick();
        check("s_a0_trans", 32'(htrans), 32'(HTRANS_NONSEQ));
        check("s_a0_addr",  haddr, 32'h0);
        check("s_a0_valid", 32'(if_valid), 32'h0);
        tick();
        check("s_a1_addr",  haddr, 32'h4);
        check("s_a1_valid", 32'(if_valid), 32'h0);
        tick();
        check("s_a2_addr",  haddr, 32'h8);
        check("s_a2_valid", 32'(if_valid), 32'h1);
        check("s_a2_pc",    if_pc, 32'h0);
        check("s_a2_instr", if_instr, mem_word(32'h0));
        tick();
        check("s_a3_pc",    if_pc, 32'h4);
        check("s_a3_addr",  haddr, 32'hC);
        tick();
        check("s_a4_pc",    if_pc, 32'h8);
        check("s_a4_instr", if_instr, mem_word(32'h8));

        // Back-pressure fills the FIFO and stops issue at four
        if_ready = 1'b0;
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (htrans == HTRANS_NONSEQ && hready) n_acc++;
        end
        check("full_n_addr", 32'(n_acc), 32'd4);
        check("full_idle",   32'(htrans), 32'(HTRANS_IDLE));
        check("full_haddr",  haddr, 32'h10);
        check("full_pc",     if_pc, 32'h0);
        if_ready = 1'b1;
        tick();
        check("drain_pc4",   if_pc, 32'h4);
        check("drain_trans", 32'(htrans), 32'(HTRANS_NONSEQ));
        check("drain_addr",  haddr, 32'h10);
        tick();
        check("drain_pc8",   if_pc, 32'h8);
        tick();
        check("drain_pcC",   if_pc, 32'hC);
        tick();
        check("drain_pc10",  if_pc, 32'h10);
        check("drain_valid", 32'(if_valid), 32'h1);

        // Three wait states on the data phase of 0x8
        do_reset();
        repeat (4) tick();
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ws_addr_hold",  haddr, 32'hC);
            check("ws_trans_hold", 32'(htrans), 32'(HTRANS_NONSEQ));
            if (i < 2) tick();
        end
        check("ws_empty", 32'(if_valid), 32'h0);
        tick();
        hready = 1'b1;
        tick();
        check("ws_pc8",    if_pc, 32'h8);
        check("ws_instr8", if_instr, mem_word(32'h8));
        tick();
        check("ws_pcC",    if_pc, 32'hC);
        check("ws_validC", 32'(if_valid), 32'h1);

        // Redirect while 0x10 is in its data phase
        do_reset();
        repeat (6) tick();
        check("rd_pre_addr", haddr, 32'h14);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        check("rd_r1_trans", 32'(htrans), 32'(HTRANS_NONSEQ));
        check("rd_r1_addr",  haddr, 32'h100);
        check("rd_r1_empty", 32'(if_valid), 32'h0);
        tick();
        check("rd_r2_empty", 32'(if_valid), 32'h0);
        tick();
        check("rd_r3_valid", 32'(if_valid), 32'h1);
        check("rd_r3_pc",    if_pc, 32'h100);
        check("rd_r3_instr", if_instr, mem_word(32'h100));
        tick();
        check("rd_r4_pc",    if_pc, 32'h104);

        // Error response on the data phase of 0x20
        do_reset();
        repeat (10) tick();
        check("er_pre_addr", haddr, 32'h24);
        hready = 1'b0;
        hresp  = 1'b1;
        #1;
`ifdef RISCV_FETCH_BUS_ERR_EN
        check("er_first_idle", 32'(htrans), 32'(HTRANS_IDLE));
`else
        check("er_first_hold", 32'(htrans), 32'(HTRANS_NONSEQ));
`endif
        tick();
        hready = 1'b1;
`ifdef RISCV_FETCH_BUS_ERR_EN
        check("er_second_idle", 32'(htrans), 32'(HTRANS_IDLE));
`endif
        tick();
        hresp = 1'b0;
        check("er_valid", 32'(if_valid), 32'h1);
        check("er_pc",    if_pc, 32'h20);
`ifdef RISCV_FETCH_BUS_ERR_EN
        check("er_err",   32'(if_err), 32'h1);
        check("er_instr", if_instr, 32'h0);
        check("er_halt_idle", 32'(htrans), 32'(HTRANS_IDLE));
        tick();
        check("er_halt_idle2", 32'(htrans), 32'(HTRANS_IDLE));
`else
        check("er_err",   32'(if_err), 32'h0);
        check("er_instr", if_instr, mem_word(32'h20));
        tick();
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check("er_resume_trans", 32'(htrans), 32'(HTRANS_NONSEQ));
        check("er_resume_addr",  haddr, 32'h40);

        // Reset asserted in the middle of a stall
        if_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        hready = 1'b0;
        #1;
        check("mr_pre_valid", 32'(if_valid), 32'h1);
        check("mr_pre_addr",  haddr, 32'hC);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_htrans",   32'(htrans), 32'(HTRANS_IDLE));
        check("mr_haddr",    haddr, 32'h0);
        check("mr_if_valid", 32'(if_valid), 32'h0);
        check("mr_if_pc",    if_pc, 32'h0);
        check("mr_if_instr", if_instr, 32'h0);
        tick();
        hready = 1'b1;
        rst_n  = 1'b1;
        tick();
        check("mr_first_trans", 32'(htrans), 32'(HTRANS_NONSEQ));
        check("mr_first_addr",  haddr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
